// File: rtl/timer_sequencer.sv
// Command stage for the 16-bit one-shot countdown timer: queues tagged delay
// requests, issues them one at a time, and reports each completion by tag.
module timer_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [15:0]              req_cycles,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic                     abort,
    output logic                     timer_load,
    output logic [15:0]              timer_cycles,
    input  logic                     timer_busy,
    output logic                     done,
    output logic [TAG_W-1:0]         done_tag,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CYC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               timer_load_q, timer_load_d;
    logic [CYC_W-1:0]   timer_cycles_q, timer_cycles_d;
    logic               done_q, done_d;
    logic [TAG_W-1:0]   done_tag_q, done_tag_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;

    logic [CYC_W-1:0]   cyc_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem [DEPTH];

    logic               push;
    logic               pop;
    logic [CYC_W-1:0]   head_cycles;
    logic [TAG_W-1:0]   head_tag;

    // Ready depends only on registered occupancy and reset, never on req_valid.
    assign req_ready   = !reset && (count_q != CNT_W'(DEPTH));
    assign push        = req_valid && req_ready && !abort;
    assign head_cycles = cyc_mem[rd_ptr_q];
    assign head_tag    = tag_mem[rd_ptr_q];

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        timer_load_d   = 1'b0;
        timer_cycles_d = timer_cycles_q;
        done_d         = 1'b0;
        done_tag_d     = done_tag_q;
        cur_tag_d      = cur_tag_q;
        pop            = 1'b0;

        if (abort) begin
            // Flush the queue; in-flight work is abandoned without a done.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            case (state_q)
                ST_LOAD, ST_WAIT: state_d = ST_DRAIN;
                ST_DRAIN:         if (!timer_busy) state_d = ST_IDLE;
                default:          state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((count_q != '0) && !timer_busy) begin
                        pop = 1'b1;
                        if (head_cycles != '0) begin
                            state_d        = ST_LOAD;
                            timer_load_d   = 1'b1;
                            timer_cycles_d = head_cycles;
                            cur_tag_d      = head_tag;
                        end else begin
                            // Zero-length request completes without touching the timer.
                            done_d     = 1'b1;
                            done_tag_d = head_tag;
                        end
                    end
                end
                ST_LOAD: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (!timer_busy) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        done_tag_d = cur_tag_q;
                    end
                end
                ST_DRAIN: if (!timer_busy) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            timer_load_q   <= 1'b0;
            timer_cycles_q <= '0;
            done_q         <= 1'b0;
            done_tag_q     <= '0;
            cur_tag_q      <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            timer_load_q   <= timer_load_d;
            timer_cycles_q <= timer_cycles_d;
            done_q         <= done_d;
            done_tag_q     <= done_tag_d;
            cur_tag_q      <= cur_tag_d;
        end
    end

    // Queue storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            cyc_mem[wr_ptr_q] <= req_cycles;
            tag_mem[wr_ptr_q] <= req_tag;
        end
    end

    assign timer_load   = timer_load_q;
    assign timer_cycles = timer_cycles_q;
    assign done         = done_q;
    assign done_tag     = done_tag_q;
    assign pending      = count_q;
    assign idle         = (count_q == '0) && (state_q == ST_IDLE) && !timer_busy;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: a countdown-timer model as the load, a schedule-based
// reference model of issue/complete times, and directed plus randomized stimulus.
module tb_timer_sequencer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int MAXC  = 8192;
    localparam int HORIZ = 300;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [15:0]        req_cycles;
    logic [TAG_W-1:0]   req_tag;
    logic               abort;
    logic               timer_load;
    logic [15:0]        timer_cycles;
    logic               timer_busy;
    logic               done;
    logic [TAG_W-1:0]   done_tag;
    logic [$clog2(DEPTH):0] pending;
    logic               idle;

    timer_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cycles(req_cycles), .req_tag(req_tag), .abort(abort),
        .timer_load(timer_load), .timer_cycles(timer_cycles), .timer_busy(timer_busy),
        .done(done), .done_tag(done_tag), .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    // One-shot countdown timer sharing the reset.
    logic [15:0] tmr_cnt = '0;
    always @(posedge clk) begin
        if (reset)                tmr_cnt <= '0;
        else if (timer_load)      tmr_cnt <= timer_cycles;
        else if (tmr_cnt != '0)   tmr_cnt <= tmr_cnt - 16'd1;
    end
    assign timer_busy = (tmr_cnt != '0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference model: queue of requests plus per-cycle schedules of expected events.
    typedef struct {
        int cycles;
        int tag;
    } req_t;

    req_t q[$];
    bit   exp_load [MAXC];
    int   exp_lcyc [MAXC];
    bit   exp_done [MAXC];
    int   exp_dtag [MAXC];
    int   free_at     = 0;
    int   last_l      = 0;
    int   last_c      = 0;
    bit   inflight    = 0;
    bit   draining    = 0;
    int   last_cycles = 0;

    int load_cnt = 0, done_cnt = 0;
    int last_load_cyc = 0, last_done_cyc = 0, last_done_tag = 0, last_acc_cyc = 0;
    int done_tags[$];
    bit saw_full = 0;

    always @(negedge clk) begin
        int   t;
        bit   acc;
        int   qsz;
        req_t r;
        t   = cyc;
        qsz = q.size();
        acc = req_valid && !reset && !abort && (qsz != DEPTH);

        if (t >= 1 && t < MAXC - 2 * HORIZ) begin
            if (exp_load[t]) last_cycles = exp_lcyc[t];
            chk("timer_load", timer_load, exp_load[t]);
            chk("timer_cycles", timer_cycles, last_cycles);
            chk("done", done, exp_done[t]);
            if (exp_done[t]) chk("done_tag", done_tag, exp_dtag[t]);
            chk("pending", pending, qsz);
            chk("req_ready", req_ready, !reset && (qsz != DEPTH));
            chk("idle", idle, (qsz == 0) && (t >= free_at) && !timer_busy);
            chk("load_while_busy", timer_load && timer_busy, 0);

            if (timer_load) begin load_cnt++; last_load_cyc = t; end
            if (done) begin
                done_cnt++; last_done_cyc = t; last_done_tag = int'(done_tag);
                done_tags.push_back(int'(done_tag));
            end
            if (pending == DEPTH && !req_ready) saw_full = 1;
            if (acc) last_acc_cyc = t;
        end

        if (t < MAXC - 2 * HORIZ) begin
            if (reset) begin
                q.delete();
                for (int i = t + 1; i <= t + HORIZ; i++) begin
                    exp_load[i] = 0; exp_done[i] = 0;
                end
                free_at = t + 1; inflight = 0; draining = 0; last_cycles = 0;
            end else if (abort) begin
                q.delete();
                for (int i = t + 1; i <= t + HORIZ; i++) exp_done[i] = 0;
                if (inflight && t < free_at && !draining) begin
                    free_at  = ((t + 1 > last_l + last_c + 1) ? t + 1 : last_l + last_c + 1) + 1;
                    draining = 1;
                end
            end else begin
                if (t >= free_at && qsz > 0) begin
                    r = q.pop_front();
                    if (r.cycles == 0) begin
                        exp_done[t + 1] = 1; exp_dtag[t + 1] = r.tag;
                        free_at = t + 1; inflight = 0;
                    end else begin
                        exp_load[t + 1] = 1; exp_lcyc[t + 1] = r.cycles;
                        last_l = t + 1; last_c = r.cycles;
                        exp_done[t + r.cycles + 3] = 1; exp_dtag[t + r.cycles + 3] = r.tag;
                        free_at = t + r.cycles + 3; inflight = 1; draining = 0;
                    end
                end
                if (acc) begin
                    r.cycles = int'(req_cycles); r.tag = int'(req_tag);
                    q.push_back(r);
                end
            end
        end
    end

    task automatic drive(bit v, int c, int tg, bit ab);
        req_valid  = v;
        req_cycles = 16'(c);
        req_tag    = TAG_W'(tg);
        abort      = ab;
    endtask

    task automatic step(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_one(int c, int tg);
        int n;
        n = 0;
        drive(1, c, tg, 0);
        @(negedge clk);
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) timeout_fail("push_wait");
        @(posedge clk); #1;
        drive(0, 0, 0, 0);
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!idle && n < budget) begin @(negedge clk); n++; end
        if (n >= budget) timeout_fail("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l0, target;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        step(3);
        reset = 1'b0;

        // Single request: load 2 cycles after acceptance, done 5 after load.
        d0 = done_cnt;
        push_one(3, 1);
        step(2);
        wait_idle(50);
        chk("t1_load_after_acc", last_load_cyc - last_acc_cyc, 2);
        chk("t1_done_after_load", last_done_cyc - last_load_cyc, 5);
        chk("t1_done_tag", last_done_tag, 1);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_idle", idle, 1);

        // Back-to-back pushes fill the FIFO; completions stay in order.
        d0 = done_tags.size();
        push_one(2, 0); push_one(5, 1); push_one(1, 2); push_one(7, 3); push_one(1, 4);
        step(1);
        wait_idle(300);
        chk("t2_full_seen", saw_full, 1);
        chk("t2_done_count", done_tags.size() - d0, 5);
        for (int i = 0; i < 5; i++) chk("t2_done_order", done_tags[d0 + i], i);

        // Zero-length request bypasses the timer.
        l0 = load_cnt;
        push_one(0, 9);
        step(1);
        wait_idle(20);
        chk("t3_no_load", load_cnt - l0, 0);
        chk("t3_done_after_acc", last_done_cyc - last_acc_cyc, 2);
        chk("t3_done_tag", last_done_tag, 9);

        // Abort mid-wait: queue flushed, no completions, then normal operation.
        d0 = done_cnt; l0 = load_cnt;
        push_one(100, 2); push_one(3, 3); push_one(4, 4);
        target = last_load_cyc + 10;
        while (cyc < target) step(1);
        drive(1, 5, 7, 1);
        step(1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t4_pending_after_abort", pending, 0);
        @(posedge clk); #1;
        wait_idle(200);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_one_load", load_cnt - l0, 1);
        push_one(1, 5);
        step(1);
        wait_idle(20);
        chk("t4_new_done_count", done_cnt - d0, 1);
        chk("t4_new_done_tag", last_done_tag, 5);

        // Reset while waiting with two queued requests.
        push_one(20, 1); push_one(2, 2); push_one(3, 3);
        target = last_load_cyc + 3;
        while (cyc < target) step(1);
        @(negedge clk);
        chk("t5_pending_before", pending, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);
        @(negedge clk);
        chk("t5_done", done, 0);
        chk("t5_pending", pending, 0);
        chk("t5_timer_load", timer_load, 0);
        chk("t5_ready_in_reset", req_ready, 0);
        chk("t5_done_tag", done_tag, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready_after", req_ready, 1);
        @(posedge clk); #1;

        // Randomized traffic with mostly-held valid and rare aborts.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 6),
                  $urandom_range(0, 15), $urandom_range(0, 99) < 2);
            step(1);
        end
        drive(0, 0, 0, 0);
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
